// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage.
package wb_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    // One result headed for the register file: destination plus value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_result_t;

endpackage

// File: rtl/writeback_unit_if.sv
// Bundle of decode, ALU, load and register-file signals around the write-back stage.
// Build option: WB_BYPASS_EN adds the rs1/rs2 forwarding outputs.
interface writeback_unit_if;
    import wb_pkg::*;

    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic                  issue_stall;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic                  rs1_pending;
    logic                  rs2_pending;
    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  ld_valid;
    logic [REG_ADDR_W-1:0] ld_rd;
    logic [XLEN-1:0]       ld_data;
    logic                  ld_ready;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       write_data;
`ifdef WB_BYPASS_EN
    logic                  rs1_fwd_valid;
    logic                  rs2_fwd_valid;
    logic [XLEN-1:0]       rs1_fwd_data;
    logic [XLEN-1:0]       rs2_fwd_data;
`endif

    // Pipeline side: decode, execute and memory stages.
    modport master (
        output issue_valid, issue_rd, rs1_addr, rs2_addr,
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input  issue_stall, rs1_pending, rs2_pending, ld_ready,
        input  reg_write, rd_addr, write_data
`ifdef WB_BYPASS_EN
        , input rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_data, rs2_fwd_data
`endif
    );

    // Write-back unit side.
    modport slave (
        input  issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output issue_stall, rs1_pending, rs2_pending, ld_ready,
        output reg_write, rd_addr, write_data
`ifdef WB_BYPASS_EN
        , output rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_data, rs2_fwd_data
`endif
    );

endinterface

// File: rtl/wb_load_fifo.sv
// Load-result buffer: LQ_DEPTH-entry FIFO with wrap-bit pointers (LQ_DEPTH power of two).
module wb_load_fifo
    import wb_pkg::*;
#(
    parameter int unsigned LQ_DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  wb_result_t push_data,
    input  logic       pop,
    output wb_result_t head,
    output logic       full,
    output logic       empty
);

    localparam int unsigned PTR_W = $clog2(LQ_DEPTH);

    wb_result_t       mem [LQ_DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap bits means the buffer has lapped the reader.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_q[PTR_W-1:0]];

    // Pointer update; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    // Entry storage; stale slots are masked by the pointers so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: pending-write scoreboard, ALU/load arbiter and registered write port.
// Build option: WB_BYPASS_EN forwards the in-flight write to decode sources.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int unsigned LQ_DEPTH = 2
) (
    input logic             clk,
    input logic             reset,
    writeback_unit_if.slave wb
);

    logic [NUM_REGS-1:0]   pending_q;
    logic [NUM_REGS-1:0]   pending_d;
    logic                  reg_write_q;
    logic [REG_ADDR_W-1:0] rd_addr_q;
    logic [XLEN-1:0]       write_data_q;

    wb_result_t alu_res;
    wb_result_t ld_res;
    wb_result_t fifo_head;
    wb_result_t sel_res;
    logic       sel_valid;
    logic       sel_write;
    logic       ld_fire;
    logic       ld_direct;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       issue_stall;
    logic       issue_fire;
    logic       rs1_fwd;
    logic       rs2_fwd;

    assign alu_res = '{rd: wb.alu_rd, data: wb.alu_data};
    assign ld_res  = '{rd: wb.ld_rd, data: wb.ld_data};

    assign wb.ld_ready = reset && !fifo_full;
    assign ld_fire     = wb.ld_valid && wb.ld_ready;
    // An idle ALU with an empty buffer lets the arriving load go straight to the write port.
    assign ld_direct   = ld_fire && !wb.alu_valid && fifo_empty;
    assign fifo_push   = ld_fire && !ld_direct;
    assign fifo_pop    = !wb.alu_valid && !fifo_empty;

    wb_load_fifo #(
        .LQ_DEPTH (LQ_DEPTH)
    ) u_load_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (ld_res),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Arbiter: ALU always wins, then the oldest buffered load, then a fresh load.
    always_comb begin
        sel_valid = 1'b0;
        sel_res   = alu_res;
        if (wb.alu_valid) begin
            sel_valid = 1'b1;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_res   = fifo_head;
        end else if (ld_direct) begin
            sel_valid = 1'b1;
            sel_res   = ld_res;
        end
    end

    // Writes to x0 are dropped here, after any buffer pop has been taken.
    assign sel_write = sel_valid && (sel_res.rd != '0);

    // Registered register-file write port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            reg_write_q  <= 1'b0;
            rd_addr_q    <= '0;
            write_data_q <= '0;
        end else begin
            reg_write_q <= sel_write;
            if (sel_write) begin
                rd_addr_q    <= sel_res.rd;
                write_data_q <= sel_res.data;
            end
        end
    end

    assign wb.reg_write  = reg_write_q;
    assign wb.rd_addr    = rd_addr_q;
    assign wb.write_data = write_data_q;

    assign issue_stall    = wb.issue_valid && (wb.issue_rd != '0) && pending_q[wb.issue_rd];
    assign issue_fire     = wb.issue_valid && !issue_stall && (wb.issue_rd != '0);
    assign wb.issue_stall = issue_stall;

    // Scoreboard next state: the completing write clears, a new issue sets and wins.
    always_comb begin
        pending_d = pending_q;
        if (reg_write_q) pending_d[rd_addr_q] = 1'b0;
        if (issue_fire)  pending_d[wb.issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!reset) pending_q <= '0;
        else        pending_q <= pending_d;
    end

`ifdef WB_BYPASS_EN
    assign rs1_fwd = reg_write_q && (rd_addr_q == wb.rs1_addr) && (wb.rs1_addr != '0);
    assign rs2_fwd = reg_write_q && (rd_addr_q == wb.rs2_addr) && (wb.rs2_addr != '0);
    assign wb.rs1_fwd_valid = rs1_fwd;
    assign wb.rs2_fwd_valid = rs2_fwd;
    assign wb.rs1_fwd_data  = write_data_q;
    assign wb.rs2_fwd_data  = write_data_q;
`else
    assign rs1_fwd = 1'b0;
    assign rs2_fwd = 1'b0;
`endif

    // A forwarded source no longer needs to wait for the register file.
    assign wb.rs1_pending = (wb.rs1_addr != '0) && pending_q[wb.rs1_addr] && !rs1_fwd;
    assign wb.rs2_pending = (wb.rs2_addr != '0) && pending_q[wb.rs2_addr] && !rs2_fwd;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios then random traffic, all checked
// against a queue-based model of the write-back rules.
module tb_writeback_unit;
    import wb_pkg::*;

    localparam int unsigned LQ_DEPTH = 2;

    logic clk = 1'b0;
    logic reset;

    writeback_unit_if bus ();

    writeback_unit #(
        .LQ_DEPTH (LQ_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: set of registers awaiting a write, queue of waiting loads,
    // and the value currently presented on the write port.
    bit         m_pend [NUM_REGS];
    wb_result_t m_q [$];
    bit         m_we;
    bit [4:0]   m_addr;
    bit [31:0]  m_data;
    bit         last_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic drive_idle();
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.rs1_addr    = '0;
        bus.rs2_addr    = '0;
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = '0;
        bus.alu_data    = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_rd       = '0;
        bus.ld_data     = '0;
    endtask

    // One clock: check combinational outputs, advance the model, check the write port.
    // Entered and left at a falling edge with inputs already driven.
    task automatic cycle();
        bit         rdy, stall, f1, f2, acc, sel_v;
        wb_result_t sel;
        #1;
        rdy   = reset && (m_q.size() < LQ_DEPTH);
        stall = bus.issue_valid && bus.issue_rd != 0 && m_pend[bus.issue_rd];
        f1 = 1'b0;
        f2 = 1'b0;
`ifdef WB_BYPASS_EN
        f1 = m_we && m_addr == bus.rs1_addr && bus.rs1_addr != 0;
        f2 = m_we && m_addr == bus.rs2_addr && bus.rs2_addr != 0;
        check("rs1_fwd_valid", 32'(bus.rs1_fwd_valid), 32'(f1));
        check("rs2_fwd_valid", 32'(bus.rs2_fwd_valid), 32'(f2));
        if (f1) check("rs1_fwd_data", bus.rs1_fwd_data, m_data);
        if (f2) check("rs2_fwd_data", bus.rs2_fwd_data, m_data);
`endif
        check("ld_ready", 32'(bus.ld_ready), 32'(rdy));
        check("issue_stall", 32'(bus.issue_stall), 32'(stall));
        check("rs1_pending", 32'(bus.rs1_pending),
              32'(bus.rs1_addr != 0 && m_pend[bus.rs1_addr] && !f1));
        check("rs2_pending", 32'(bus.rs2_pending),
              32'(bus.rs2_addr != 0 && m_pend[bus.rs2_addr] && !f2));
        acc = 1'b0;
        if (!reset) begin
            model_clear();
        end else begin
            acc   = bus.ld_valid && rdy;
            sel_v = 1'b0;
            sel   = '0;
            if (bus.alu_valid) begin
                sel_v = 1'b1;
                sel   = '{rd: bus.alu_rd, data: bus.alu_data};
                if (acc) m_q.push_back('{rd: bus.ld_rd, data: bus.ld_data});
            end else begin
                // Loads are written oldest first, including one arriving now.
                if (acc) m_q.push_back('{rd: bus.ld_rd, data: bus.ld_data});
                if (m_q.size() > 0) begin
                    sel_v = 1'b1;
                    sel   = m_q.pop_front();
                end
            end
            if (m_we) m_pend[m_addr] = 1'b0;
            if (bus.issue_valid && bus.issue_rd != 0 && !stall) m_pend[bus.issue_rd] = 1'b1;
            m_we = sel_v && sel.rd != 0;
            if (m_we) begin
                m_addr = sel.rd;
                m_data = sel.data;
            end
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        check("reg_write", 32'(bus.reg_write), 32'(m_we));
        check("rd_addr", 32'(bus.rd_addr), 32'(m_addr));
        check("write_data", bus.write_data, m_data);
        @(negedge clk);
    endtask

    int li;

    initial begin
        reset = 1'b0;
        drive_idle();
        model_clear();
        last_acc = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset held three cycles, then issue x5 and write it from the ALU.
        repeat (3) cycle();
        reset = 1'b1;
        #1 check("ld_ready_after_release", 32'(bus.ld_ready), 32'd1);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd5;
        cycle();
        bus.issue_valid = 1'b0;
        bus.rs1_addr    = 5'd5;
        #1 check("rs1_pending_x5", 32'(bus.rs1_pending), 32'd1);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'hDEADBEEF;
        cycle();
        check("x5_reg_write", 32'(bus.reg_write), 32'd1);
        check("x5_rd_addr", 32'(bus.rd_addr), 32'd5);
        check("x5_data", bus.write_data, 32'hDEADBEEF);
        bus.alu_valid = 1'b0;
`ifdef WB_BYPASS_EN
        #1 check("x5_pending_fwd", 32'(bus.rs1_pending), 32'd0);
`else
        #1 check("x5_pending_write_cycle", 32'(bus.rs1_pending), 32'd1);
`endif
        cycle();
        #1 check("x5_pending_cleared", 32'(bus.rs1_pending), 32'd0);
        cycle();

        // WAW: second issue of x7 stalls until the x7 write has landed.
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        cycle();
        #1 check("waw_stall", 32'(bus.issue_stall), 32'd1);
        cycle();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd7;
        bus.alu_data  = 32'h0000_0777;
        cycle();
        bus.alu_valid = 1'b0;
        #1 check("waw_stall_write_cycle", 32'(bus.issue_stall), 32'd1);
        cycle();
        #1 check("waw_stall_released", 32'(bus.issue_stall), 32'd0);
        cycle();
        drive_idle();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd7;
        cycle();
        drive_idle();
        cycle();

        // ALU and load in the same cycle: ALU first, load next.
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        bus.alu_data  = 32'h11;
        bus.ld_valid  = 1'b1;
        bus.ld_rd     = 5'd4;
        bus.ld_data   = 32'h22;
        cycle();
        check("arb_first", 32'(bus.rd_addr), 32'd3);
        drive_idle();
        cycle();
        check("arb_second", 32'(bus.rd_addr), 32'd4);
        check("arb_second_data", bus.write_data, 32'h22);
        cycle();

        // Buffer full: ALU busy six cycles while loads x8..x10 arrive.
        li = 0;
        for (int c = 0; c < 6; c++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'd20;
            bus.alu_data  = 32'(c);
            bus.ld_valid  = (li < 3);
            bus.ld_rd     = 5'(8 + li);
            bus.ld_data   = 32'h100 + 32'(li);
            cycle();
            if (last_acc) li++;
        end
        #1 check("full_ld_ready", 32'(bus.ld_ready), 32'd0);
        bus.alu_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.ld_valid = (li < 3);
            bus.ld_rd    = 5'(8 + li);
            bus.ld_data  = 32'h100 + 32'(li);
            cycle();
            if (c == 0) check("drain_first", 32'(bus.rd_addr), 32'd8);
            if (c == 1) check("drain_second", 32'(bus.rd_addr), 32'd9);
            if (last_acc) li++;
        end
        drive_idle();

        // x0 results are discarded.
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 32'h55;
        cycle();
        check("x0_no_write", 32'(bus.reg_write), 32'd0);

        // Reset with two loads buffered and x9 pending.
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        bus.alu_rd      = 5'd21;
        for (int c = 0; c < 2; c++) begin
            bus.ld_valid = 1'b1;
            bus.ld_rd    = 5'(11 + c);
            bus.ld_data  = 32'h200 + 32'(c);
            cycle();
            bus.issue_valid = 1'b0;
        end
        drive_idle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        bus.rs1_addr = 5'd9;
        for (int c = 0; c < 3; c++) begin
            #1 check("post_reset_pending", 32'(bus.rs1_pending), 32'd0);
            cycle();
            check("post_reset_no_write", 32'(bus.reg_write), 32'd0);
        end

        // Write of x12 while decode reads x12 as rs2.
        drive_idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd12;
        cycle();
        drive_idle();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd12;
        bus.alu_data  = 32'hCAFE0001;
        cycle();
        drive_idle();
        bus.rs2_addr = 5'd12;
`ifdef WB_BYPASS_EN
        #1;
        check("fwd_valid_x12", 32'(bus.rs2_fwd_valid), 32'd1);
        check("fwd_data_x12", bus.rs2_fwd_data, 32'hCAFE0001);
        check("fwd_pending_x12", 32'(bus.rs2_pending), 32'd0);
`else
        #1 check("pending_x12_write_cycle", 32'(bus.rs2_pending), 32'd1);
`endif
        cycle();

        // Random traffic over a small register range to provoke hazards.
        for (int c = 0; c < 400; c++) begin
            reset           = ($urandom_range(0, 59) != 0);
            bus.issue_valid = ($urandom_range(0, 2) == 0);
            bus.issue_rd    = 5'($urandom_range(0, 7));
            bus.rs1_addr    = 5'($urandom_range(0, 7));
            bus.rs2_addr    = 5'($urandom_range(0, 7));
            bus.alu_valid   = ($urandom_range(0, 4) < 2);
            bus.alu_rd      = 5'($urandom_range(0, 7));
            bus.alu_data    = $urandom;
            // A refused load is held until it is taken.
            if (!bus.ld_valid || last_acc) begin
                bus.ld_valid = ($urandom_range(0, 1) == 1);
                bus.ld_rd    = 5'($urandom_range(0, 7));
                bus.ld_data  = $urandom;
            end
            cycle();
        end
        reset = 1'b1;
        drive_idle();
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
